// File: rtl/rr_mux_sel_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_sel_arbiter_pkg
// Description : State encoding, pick result type and round-robin helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_mux_sel_arbiter_pkg;

   localparam int C_MAX_N = 32;
   localparam int C_IDX_W = 5;

   localparam logic [0:0] c_idle = 1'b0;
   localparam logic [0:0] c_hold = 1'b1;

   typedef struct packed {
      logic [C_IDX_W-1:0] idx;
      logic               found;
   } pick_t;

   function automatic logic [C_MAX_N-1:0] onehot(input logic [C_IDX_W-1:0] k);
      return C_MAX_N'(1) << k;
   endfunction

   // Scan ptr+1 .. ptr+n (mod n); the first unmasked request wins.
   function automatic pick_t rr_pick_fn(input logic [C_MAX_N-1:0] req,
                                        input logic [C_MAX_N-1:0] mask,
                                        input int                 ptr,
                                        input int                 n);
      pick_t              res;
      logic [C_IDX_W-1:0] j;
      res = '0;
      for (int i = 1; i <= C_MAX_N; i++) begin
         if (i <= n) begin
            j = C_IDX_W'((ptr + i) % n);
            if (req[j] && !mask[j] && !res.found) begin
               res.found = 1'b1;
               res.idx   = j;
            end
         end
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_mux_sel_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotate-priority picker over N requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
   import rr_mux_sel_arbiter_pkg::*;
#(
   parameter int N = 4,
   parameter int M = 2
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] mask,
   input  logic [M-1:0] ptr,
   output logic [M-1:0] idx,
   output logic         found
);

   pick_t w_res;
   logic  w_unused;

   always_comb begin
      w_res    = rr_pick_fn(C_MAX_N'(req), C_MAX_N'(mask), int'(ptr), N);
      idx      = w_res.idx[M-1:0];
      found    = w_res.found;
      w_unused = ^w_res.idx;
   end

endmodule
`default_nettype wire

// File: rtl/rr_mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_sel_arbiter
// Description : Round-robin arbiter driving a registered mux select and word.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_sel_arbiter
   import rr_mux_sel_arbiter_pkg::*;
#(
   parameter int N = 4,
   parameter int M = 2,
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] in_data,
   output logic [N-1:0]   in_ack,
   output logic [M-1:0]   sel,
   output logic [N-1:0]   grant,
   output logic           out_valid,
   output logic [W-1:0]   out_data,
   input  logic           out_ready
);

   logic [0:0]   r_state;
   logic [M-1:0] r_ptr;
   logic [M-1:0] r_sel;
   logic [N-1:0] r_grant;
   logic         r_valid;
   logic [W-1:0] r_data;

   logic         w_accept;
   logic [M-1:0] w_pick_ptr;
   logic [N-1:0] w_mask;
   logic [M-1:0] w_idx;
   logic         w_found;
   logic [W-1:0] w_slice [N];

   for (genvar k = 0; k < N; k++) begin : g_slice
      assign w_slice[k] = in_data[k*W +: W];
   end

   // On accept, re-arbitrate from the word just delivered, skipping its owner.
   always_comb begin
      w_accept   = r_valid && out_ready;
      w_pick_ptr = (r_state == c_idle) ? r_ptr : r_sel;
      w_mask     = w_accept ? r_grant : '0;
   end

   rr_pick #(
      .N (N),
      .M (M)
   ) u_pick (
      .req   (req),
      .mask  (w_mask),
      .ptr   (w_pick_ptr),
      .idx   (w_idx),
      .found (w_found)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_idle;
         r_ptr   <= M'(N-1);
         r_sel   <= '0;
         r_grant <= '0;
         r_valid <= 1'b0;
         r_data  <= '0;
      end else begin
         case (r_state)
            c_idle: begin
               if (w_found) begin
                  r_sel   <= w_idx;
                  r_grant <= N'(onehot(C_IDX_W'(w_idx)));
                  r_data  <= w_slice[w_idx];
                  r_valid <= 1'b1;
                  r_state <= c_hold;
               end
            end
            c_hold: begin
               if (w_accept) begin
                  r_ptr <= r_sel;
                  if (w_found) begin
                     r_sel   <= w_idx;
                     r_grant <= N'(onehot(C_IDX_W'(w_idx)));
                     r_data  <= w_slice[w_idx];
                  end else begin
                     r_valid <= 1'b0;
                     r_grant <= '0;
                     r_state <= c_idle;
                  end
               end
            end
            default: r_state <= c_idle;
         endcase
      end
   end

   always_comb begin
      sel       = r_sel;
      grant     = r_grant;
      out_valid = r_valid;
      out_data  = r_data;
      in_ack    = w_accept ? r_grant : '0;
   end

endmodule
`default_nettype wire

// File: doc/rr_mux_sel_arbiter.md
Name: rr_mux_sel_arbiter

Overview:
- Upstream control stage for the W-bit N-input select multiplexer.
- Arbitrates among N requesters with a round-robin policy.
- Drives the binary select code and a one-hot grant.
- Captures the selected requester's W-bit word into an output register.
- Hands that word downstream over a valid/ready handshake, so the mux data path gets a registered, stall-safe select source.

Parameters:
- N, 4, number of requesters / mux inputs.
- m, 2, select width; N <= 2**m required.
- W, 4, data width per input.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N  per-requester request level; bit k belongs to requester k.
- in_data  input  N*W  flat input bus; requester k occupies bits [k*W +: W].
- in_ack  output  N  one-hot, one-cycle pulse on the cycle requester k's word is accepted downstream.
- sel  output  m  binary index of the current grant; value k selects slice k; feeds the mux select.
- grant  output  N  one-hot current grant; all-zero when idle.
- out_valid  output  1  out_data holds a granted word.
- out_data  output  W  registered copy of the granted word.
- out_ready  input  1  downstream accepts when out_valid && out_ready.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values: sel=0, grant=0, out_valid=0, out_data=0, in_ack=0, last-grant pointer ptr=N-1, state=IDLE. Requester 0 therefore has top priority after reset.
- Reset mid-transfer: the pending word is dropped, no in_ack is issued, and all outputs return to reset values on the next edge.
- Priority order: indices ptr+1, ptr+2, ..., ptr+N, all mod N. The first asserted req in that order wins. Wrap from N-1 to 0 is required.
- State IDLE:
  - grant=0 and out_valid=0.
  - If any req bit is set, the winner k is chosen and registered on the same edge: sel<=k, grant<=onehot(k), out_data<=in_data[k*W +: W], out_valid<=1. Next state is HOLD.
  - Latency from req rising to out_valid is 1 cycle.
- State HOLD:
  - out_valid=1. sel, grant and out_data stay stable while out_ready=0. Later changes to in_data or req have no effect.
  - On accept (out_valid && out_ready), all of the following happen:
    - in_ack[sel] pulses high in that same cycle (combinational from accept).
    - ptr<=sel.
    - A new arbitration runs the same cycle with the accepted requester masked out. The requester must drop req on the edge after in_ack.
    - If another req wins, it is granted and captured on that edge, state stays HOLD, and out_valid stays 1. This gives back-to-back transfers at 1 word/cycle.
    - If no other req wins, the block goes to IDLE with out_valid<=0 and grant<=0. sel holds its last value.
- Mid-hold changes: a requester that drops req while granted in HOLD is ignored; the captured word is still delivered. No retraction is allowed.
- No requests: with req=0, the block stays in IDLE indefinitely and ptr is unchanged.
- Invariants:
  - grant is one-hot or zero.
  - grant[sel]=1 whenever out_valid=1.
  - in_ack is never non-zero when out_ready=0.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=1'b0, HOLD=1'b1;
  - a function for onehot(k);
  - a rotate-priority-pick function (req, mask, ptr) returning index and found flag.
- One sub-module is natural: rr_pick, combinational, taking req/ptr/mask and producing idx/found.
- The data capture may instantiate W_bit_N_MUX driven by the arbiter's next-sel.

Test Plan:
1. Hold rst for 2 cycles, then release with req=0000 → out_valid=0, grant=0000, sel=00, out_data=0000, and the block stays idle for 10 cycles.
2. req=0010 with in_data slice1=4'b0101, out_ready=1 → 1 cycle later out_valid=1, sel=01, grant=0010, out_data=0101; in_ack=0010 in that cycle; the block then returns to IDLE.
3. req=1111 held, slices 0..3 = 1,2,4,8, out_ready=1 each cycle, each acked requester re-raises req two cycles later → sel sequence 0,1,2,3,0 with out_data 1,2,4,8,1 on consecutive cycles and out_valid continuously 1.
4. Grant on requester 2 with out_ready=0 for 5 cycles while in_data slice2 toggles → out_data, sel=10 and grant stable, in_ack=0; raising out_ready gives a single in_ack=0100 pulse.
5. Assert rst in HOLD with out_valid=1 and out_ready=0 → next edge out_valid=0 and grant=0000; no in_ack; with req=1001 the next grant goes to requester 0.
6. ptr=3 (last grant was requester 3), req=1001 → requester 0 wins; after accept, requester 3 wins next, confirming wrap-around.
